// File: rtl/sp_rd_packer.sv
// sp_rd_packer
//   Packs the 32-bit readout word stream into fixed-length frames, buffers
//   whole frames in a payload FIFO and emits each one as a valid/ready stream:
//   header, FRAME_WORDS payload words, trailer (tlast).  The readout source
//   cannot be stalled, so a frame is admitted or dropped as a unit at its
//   first word.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   din, din_valid        readout word stream (no ready)
//   m_tdata/m_tvalid/
//   m_tready/m_tlast      output stream, registered
//   drop_cnt              dropped frames, saturating
//   overflow              sticky, set on first drop
//   fifo_level            payload FIFO occupancy
module sp_rd_packer #(
    parameter int          FRAME_WORDS = 64,
    parameter int          FIFO_DEPTH  = 256,
    parameter logic [15:0] HDR_TAG     = 16'hA55A,
    parameter logic [15:0] TRL_TAG     = 16'h5AA5,
    localparam int         LW          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   din,
    input  logic          din_valid,
    output logic [31:0]   m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          m_tlast,
    output logic [15:0]   drop_cnt,
    output logic          overflow,
    output logic [LW-1:0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(FRAME_WORDS);
    localparam int CW = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_t;

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [IW-1:0] r_in_idx;
    logic          r_admit;
    logic [15:0]   r_drop_cnt;
    logic          r_overflow;
    logic [15:0]   r_frame_id;
    state_t        r_state;
    logic [CW-1:0] r_out_cnt;
    logic [31:0]   r_tdata;
    logic          r_tvalid, r_tlast;

    state_t        w_nstate;
    logic          w_pop, w_fid_inc;
    logic [31:0]   w_tdata_n;
    logic          w_tvalid_n, w_tlast_n;
    logic [CW-1:0] w_out_cnt_n;
    logic [31:0]   w_head;
    logic          w_start, w_room, w_admit_now, w_wr;
    logic [LW:0]   w_free;

    assign w_head = r_mem[r_rd_ptr];

    // Free space counts a pop happening this very cycle, so a frame start
    // coinciding with the output draining the last blocking word is admitted.
    assign w_start     = din_valid && (r_in_idx == '0);
    assign w_free      = (LW+1)'(FIFO_DEPTH) - {1'b0, r_level} + (LW+1)'(w_pop);
    assign w_room      = (w_free >= (LW+1)'(FRAME_WORDS));
    assign w_admit_now = w_start ? w_room : r_admit;
    assign w_wr        = din_valid && w_admit_now;

    // Admission is decided per frame, so the FIFO only ever holds whole
    // frames and a write cannot land on a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_in_idx   <= '0;
            r_admit    <= 1'b0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (din_valid) begin
                r_in_idx <= (r_in_idx == IW'(FRAME_WORDS - 1)) ? '0 : r_in_idx + 1'b1;
            end
            if (w_start) begin
                r_admit <= w_room;
                if (!w_room) begin
                    r_overflow <= 1'b1;
                    if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + LW'(w_wr) - LW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= din;
    end

    // Output FSM: the output register is only reloaded when empty or when its
    // current word is taken, which keeps it stable under backpressure.
    always_comb begin
        w_nstate    = r_state;
        w_pop       = 1'b0;
        w_fid_inc   = 1'b0;
        w_tdata_n   = r_tdata;
        w_tvalid_n  = r_tvalid;
        w_tlast_n   = r_tlast;
        w_out_cnt_n = r_out_cnt;
        unique case (r_state)
            IDLE: begin
                if (r_level != '0) begin
                    w_tdata_n  = {HDR_TAG, r_frame_id};
                    w_tvalid_n = 1'b1;
                    w_nstate   = HDR;
                end
            end
            HDR: begin
                if (r_tvalid && m_tready) begin
                    w_tdata_n   = w_head;
                    w_pop       = 1'b1;
                    w_out_cnt_n = CW'(1);
                    w_nstate    = DATA;
                end
            end
            DATA: begin
                // !r_tvalid means a payload word is still owed but the FIFO
                // ran dry; wait for it with valid low.
                if (!r_tvalid || m_tready) begin
                    if (r_out_cnt < CW'(FRAME_WORDS)) begin
                        if (r_level != '0) begin
                            w_tdata_n   = w_head;
                            w_pop       = 1'b1;
                            w_tvalid_n  = 1'b1;
                            w_out_cnt_n = r_out_cnt + 1'b1;
                        end else begin
                            w_tvalid_n  = 1'b0;
                        end
                    end else begin
                        w_tdata_n  = {r_drop_cnt, TRL_TAG};
                        w_tlast_n  = 1'b1;
                        w_tvalid_n = 1'b1;
                        w_nstate   = TRL;
                    end
                end
            end
            TRL: begin
                if (r_tvalid && m_tready) begin
                    w_tlast_n  = 1'b0;
                    w_tvalid_n = 1'b0;
                    w_fid_inc  = 1'b1;
                    w_nstate   = IDLE;
                end
            end
            default: w_nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_out_cnt  <= '0;
            r_frame_id <= '0;
        end else begin
            r_state   <= w_nstate;
            r_tdata   <= w_tdata_n;
            r_tvalid  <= w_tvalid_n;
            r_tlast   <= w_tlast_n;
            r_out_cnt <= w_out_cnt_n;
            if (w_fid_inc) r_frame_id <= r_frame_id + 1'b1;
        end
    end

    assign m_tdata    = r_tdata;
    assign m_tvalid   = r_tvalid;
    assign m_tlast    = r_tlast;
    assign drop_cnt   = r_drop_cnt;
    assign overflow   = r_overflow;
    assign fifo_level = r_level;
endmodule

// File: tb/tb_sp_rd_packer.sv
// Directed bench for sp_rd_packer with FRAME_WORDS=4, FIFO_DEPTH=8.
// Inputs are driven and outputs sampled on the falling edge; a word seen
// with m_tvalid while m_tready is being driven high is taken at the next
// rising edge and is logged as {tlast, tdata}.
module tb_sp_rd_packer;
    localparam int FW = 4;
    localparam int FD = 8;
    localparam int LW = $clog2(FD + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   din = '0;
    logic          din_valid = 1'b0;
    logic          m_tready = 1'b0;
    logic [31:0]   m_tdata;
    logic          m_tvalid, m_tlast, overflow;
    logic [15:0]   drop_cnt;
    logic [LW-1:0] fifo_level;

    sp_rd_packer #(.FRAME_WORDS(FW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .drop_cnt(drop_cnt), .overflow(overflow),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [32:0] got [$];
    logic [32:0] exp_q [$];
    logic        prev_stall = 1'b0;
    logic [32:0] prev_word  = '0;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // One cycle: sample at the falling edge, then drive the next inputs.
    task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic rs);
        @(negedge clk);
        if (prev_stall) begin
            chk("hold_word", {m_tlast, m_tdata}, prev_word);
            chk("hold_valid", 33'(m_tvalid), 33'(1));
        end
        if (!rs && m_tvalid && r) got.push_back({m_tlast, m_tdata});
        prev_stall = !rs && m_tvalid && !r;
        prev_word  = {m_tlast, m_tdata};
        rst = rs; din_valid = v; din = d; m_tready = r;
    endtask

    task automatic feed(input logic [31:0] first, input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(1'b1, first + 32'(i), r, 1'b0);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, r, 1'b0);
    endtask

    task automatic exp_frame(input logic [15:0] fid, input logic [31:0] base, input logic [15:0] dc);
        exp_q.push_back({1'b0, 16'hA55A, fid});
        for (int i = 0; i < FW; i++) exp_q.push_back({1'b0, base + 32'(i)});
        exp_q.push_back({1'b1, dc, 16'h5AA5});
    endtask

    task automatic check_words(input string tag);
        chk($sformatf("%s_count", tag), 33'(got.size()), 33'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tvalid"}, 33'(m_tvalid), 33'(0));
        chk({tag, "_tlast"},  33'(m_tlast),  33'(0));
        chk({tag, "_tdata"},  33'(m_tdata),  33'(0));
        chk({tag, "_drop"},   33'(drop_cnt), 33'(0));
        chk({tag, "_ovf"},    33'(overflow), 33'(0));
        chk({tag, "_level"},  33'(fifo_level), 33'(0));
    endtask

    initial begin
        int k;
        // Reset state
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk_zero("reset");

        // Single frame, always ready
        feed(32'd1, FW, 1'b1);
        idle(12, 1'b1);
        exp_frame(16'h0000, 32'd1, 16'h0000);
        check_words("single");
        chk("single_drop",  33'(drop_cnt),   33'(0));
        chk("single_level", 33'(fifo_level), 33'(0));

        // Second frame under ready pattern 1,0,0,1; holds checked in cyc
        for (int i = 0; i < 40; i++)
            cyc(logic'(i < FW), 32'd11 + 32'(i), logic'((i % 4 == 0) || (i % 4 == 3)), 1'b0);
        exp_frame(16'h0001, 32'd11, 16'h0000);
        check_words("bp");

        // Overflow: three frames into an 8-entry FIFO with output stalled
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        feed(32'd1, 3 * FW, 1'b0);
        idle(2, 1'b0);
        chk("ovf_level", 33'(fifo_level), 33'(8));
        chk("ovf_drop",  33'(drop_cnt),   33'(1));
        chk("ovf_flag",  33'(overflow),   33'(1));
        idle(30, 1'b1);
        exp_frame(16'h0000, 32'd1, 16'h0001);
        exp_frame(16'h0001, 32'd5, 16'h0001);
        check_words("ovf");
        chk("ovf_level_end", 33'(fifo_level), 33'(0));

        // Boundary: level 5 with a pop on the start cycle gives free=4,
        // just enough; without the same-cycle pop it would be dropped.
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        feed(32'd1, 2 * FW, 1'b0);
        idle(2, 1'b0);
        chk("bnd_level", 33'(fifo_level), 33'(8));
        idle(3, 1'b1);
        feed(32'd9, FW, 1'b1);
        idle(25, 1'b1);
        chk("bnd_drop", 33'(drop_cnt), 33'(0));
        chk("bnd_ovf",  33'(overflow), 33'(0));
        exp_frame(16'h0000, 32'd1, 16'h0000);
        exp_frame(16'h0001, 32'd5, 16'h0000);
        exp_frame(16'h0002, 32'd9, 16'h0000);
        check_words("bnd");

        // Saturation: preload the counter near its ceiling, then drop more
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        feed(32'd1, 2 * FW, 1'b0);
        dut.r_drop_cnt = 16'hFFFD;
        feed(32'd9, 3 * FW, 1'b0);
        idle(2, 1'b0);
        chk("sat_drop", 33'(drop_cnt), 33'(16'hFFFF));
        chk("sat_ovf",  33'(overflow), 33'(1));
        feed(32'd21, FW, 1'b0);
        idle(1, 1'b0);
        chk("sat_hold", 33'(drop_cnt), 33'(16'hFFFF));
        idle(30, 1'b1);
        exp_frame(16'h0000, 32'd1, 16'hFFFF);
        exp_frame(16'h0001, 32'd5, 16'hFFFF);
        check_words("sat");

        // Reset after header + 2 payload words accepted
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        k = 0;
        while (got.size() < 3 && k < 20) begin
            cyc(logic'(k < FW), 32'd21 + 32'(k), 1'b1, 1'b0);
            k++;
        end
        exp_q.push_back({1'b0, 32'hA55A0000});
        exp_q.push_back({1'b0, 32'd21});
        exp_q.push_back({1'b0, 32'd22});
        check_words("mid_pre");
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk_zero("mid_rst");
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("mid_no_word", 33'(m_tvalid), 33'(0));
        feed(32'd31, FW, 1'b1);
        idle(12, 1'b1);
        exp_frame(16'h0000, 32'd31, 16'h0000);
        check_words("mid_post");
        chk("mid_level", 33'(fifo_level), 33'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
